// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES inverse cipher:
//   NB                  - state columns (always 4 for AES)
//   NR_AES128/192/256   - the legal round counts (10, 12, 14)
//   state_t             - FSM encoding of aes_decrypt_iter
//   xtime / gmul        - GF(2^8) arithmetic, polynomial 0x11B
//   inv_mix_column      - InvMixColumns applied to one 32-bit column
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int NB        = 4;
   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Multiply by x (i.e. by 0x02) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant with an xtime chain: each set bit of c
   // adds the matching power-of-two multiple of a. No multiplier inferred.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] acc;
      p   = a;
      acc = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // col[31:24] is row 0 of the column, col[7:0] is row 3.
   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// -----------------------------------------------------------------------------
// aes_inv_sbox
// Combinational AES inverse S-box, 256-entry lookup table.
// Ports:
//   a - input byte
//   y - InvSubBytes(a)
// -----------------------------------------------------------------------------
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Entry n occupies bits 8n..8n+7 of the ascending-range vector.
   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign y = INV_SBOX[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative FIPS-197 inverse cipher: one round per clock through a single
// round datapath (InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - ciphertext handshake (ct plus key schedule w)
//   ct   [0:127]         - ciphertext, byte 0 = bits 0:7, column-major
//   w    [0:128*(NR+1)-1]- expanded key schedule, round key r at bits 128r+
//   out_valid / out_ready- plaintext handshake
//   pt   [0:127]         - recovered plaintext, same byte order as ct
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and pt and
// out_valid stay put until out_ready takes the block back to IDLE. The source
// must hold w stable from acceptance until out_valid since no copy is kept.
// -----------------------------------------------------------------------------
module aes_decrypt_iter
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [0:127]            ct,
   input  logic [0:128*(NR+1)-1]   w,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [0:127]            pt
);

   state_t       state;
   state_t       state_next;
   logic [3:0]   cnt;
   logic [0:127] blk;
   logic [0:127] isr;
   logic [0:127] isb;
   logic [0:127] rk;
   logic [0:127] ark;
   logic [0:127] imc;
   logic [3:0]   key_idx;

   // IDLE whitens with the last round key; every other state uses rk[cnt].
   // cnt has reached 0 by FINAL, so the last step naturally picks rk[0].
   assign key_idx = (state == IDLE) ? 4'(NR) : cnt;
   assign rk      = w[{key_idx, 7'b000_0000} +: 128];

   // InvShiftRows: row r rotates right by r, so output column c takes its
   // row-r byte from input column (c - r) mod 4.
   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign isr[8*(4*c+r) +: 8] = blk[8*(4*((c-r+4)%4)+r) +: 8];
      end
   end

   for (genvar k = 0; k < 4*NB; k++) begin : g_sbox
      aes_inv_sbox u_inv_sbox (
         .a (isr[8*k +: 8]),
         .y (isb[8*k +: 8])
      );
   end

   assign ark = isb ^ rk;

   for (genvar c = 0; c < NB; c++) begin : g_imc
      assign imc[32*c +: 32] = inv_mix_column(ark[32*c +: 32]);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM: next state and handshake outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = ROUND;
         end
         ROUND: begin
            if (cnt == 4'd1) state_next = FINAL;
         end
         FINAL: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers. pt is a separate register so it only moves when a
   // finished block is delivered, not when the next ciphertext is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk <= '0;
         cnt <= 4'd0;
         pt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  blk <= ct ^ rk;
                  cnt <= 4'(NR - 1);
               end
            end
            ROUND: begin
               blk <= imc;
               cnt <= cnt - 4'd1;
            end
            FINAL: begin
               blk <= ark;
               pt  <= ark;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Bench for aes_decrypt_iter with one NR=10 and one NR=14 instance. Keys are
// expanded by a small forward-AES model here (S-box derived from GF(2^8)
// inversion plus the affine map); random vectors are produced by encrypting
// random plaintext with that model. Expected plaintexts go into a queue per
// instance and are popped when the instance completes an output handshake.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         in_valid0, in_valid1, out_ready0, out_ready1;
   logic         in_ready0, in_ready1, out_valid0, out_valid1;
   logic [127:0] ct0, ct1, pt0, pt1;
   logic [0:1407] w0;
   logic [0:1919] w1;

   aes_decrypt_iter #(.NR(10)) u_dut10 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .ct(ct0), .w(w0), .out_valid(out_valid0), .out_ready(out_ready0), .pt(pt0));

   aes_decrypt_iter #(.NR(14)) u_dut14 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .ct(ct1), .w(w1), .out_valid(out_valid1), .out_ready(out_ready1), .pt(pt1));

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
   endfunction

   // Returns all round keys, round key r at [1919-128r -: 128].
   function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk);
      logic [31:0]   wd [60];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [1919:0] kx;
      kx   = '0;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gf_mul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nk+7); i++) kx[1919-32*i -: 32] = wd[i];
      return kx;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [1919:0] kx, input int nr);
      logic [127:0] s, t;
      logic [7:0]   a0, a1, a2, a3;
      s = p ^ kx[1919 -: 128];
      for (int r = 1; r <= nr; r++) begin
         for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
               t[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
         s = t;
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8];
               a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8];
               a3 = t[103-32*c -: 8];
               s[127-32*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
               s[103-32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
            end
         end
         s = s ^ kx[1919-128*r -: 128];
      end
      return s;
   endfunction

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q0[$];
   logic [127:0] exp_q1[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid0 && out_ready0) begin
            if (exp_q0.size() == 0) check("sb10_unexpected", 128'(out_valid0), 128'(0));
            else                    check("sb10_pt", pt0, exp_q0.pop_front());
         end
         if (out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) check("sb14_unexpected", 128'(out_valid1), 128'(0));
            else                    check("sb14_pt", pt1, exp_q1.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic get_in_ready(input int d);
      return (d == 0) ? in_ready0 : in_ready1;
   endfunction

   function automatic logic get_out_valid(input int d);
      return (d == 0) ? out_valid0 : out_valid1;
   endfunction

   task automatic drive(input int d, input logic v, input logic [127:0] c);
      if (d == 0) begin in_valid0 = v; ct0 = c; end
      else        begin in_valid1 = v; ct1 = c; end
   endtask

   task automatic push(input int d, input logic [127:0] e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // Offer one block, then wait until out_valid and check latency.
   task automatic run_block(input int d, input logic [127:0] c, input logic [127:0] e, input string tag);
      int n;
      int acc;
      int nr;
      nr = (d == 0) ? 10 : 14;
      n  = 0;
      while (!get_in_ready(d) && n < 50) begin tick(); n++; end
      check({tag, "_ready"}, 128'(get_in_ready(d)), 128'(1));
      drive(d, 1'b1, c);
      push(d, e);
      tick();
      acc = cyc;
      drive(d, 1'b0, 128'h0);
      check({tag, "_busy"}, 128'(get_in_ready(d)), 128'(0));
      n = 0;
      while (!get_out_valid(d) && n < 40) begin tick(); n++; end
      check({tag, "_latency"}, 128'(cyc - acc), 128'(nr));
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic [1919:0] kx_b, kx_c1, kx_c3;

   initial begin
      logic [127:0] p, p2, c, c2;
      int           n, hs, seen;

      rst = 1'b1;
      drive(0, 1'b0, 128'h0);
      drive(1, 1'b0, 128'h0);
      out_ready0 = 1'b0;
      out_ready1 = 1'b0;
      w0 = '0;
      w1 = '0;
      build_sbox();
      kx_b  = key_expand({KEY_B, 128'h0}, 4);
      kx_c1 = key_expand({KEY_C1, 128'h0}, 4);
      kx_c3 = key_expand(KEY_C3, 8);

      repeat (3) tick();
      check("rst_in_ready10",  128'(in_ready0),  128'(1));
      check("rst_out_valid10", 128'(out_valid0), 128'(0));
      check("rst_pt10",        pt0,              128'h0);
      check("rst_in_ready14",  128'(in_ready1),  128'(1));
      check("rst_out_valid14", 128'(out_valid1), 128'(0));
      check("rst_pt14",        pt1,              128'h0);
      rst = 1'b0;
      tick();

      // Known-answer vectors; out_ready held high ahead of DONE.
      out_ready0 = 1'b1;
      w0 = kx_b[1919 -: 1408];
      run_block(0, CT_B, PT_B, "kat_b");
      tick();
      w0 = kx_c1[1919 -: 1408];
      run_block(0, CT_C1, PT_C, "kat_c1");
      tick();

      // Random plaintexts under the App. B key.
      w0 = kx_b[1919 -: 1408];
      for (int i = 0; i < 3; i++) begin
         p = rand128();
         run_block(0, encrypt(p, kx_b, 10), p, "rnd10");
         tick();
      end

      // Backpressure: hold DONE for 5 cycles with stray in_valid.
      out_ready0 = 1'b0;
      p = rand128();
      run_block(0, encrypt(p, kx_b, 10), p, "bp");
      drive(0, 1'b1, rand128());
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 128'(out_valid0), 128'(1));
         check("bp_pt",        pt0,              p);
         check("bp_in_ready",  128'(in_ready0),  128'(0));
         tick();
      end
      drive(0, 1'b0, 128'h0);
      out_ready0 = 1'b1;
      tick();
      check("bp_idle_ready", 128'(in_ready0),  128'(1));
      check("bp_idle_valid", 128'(out_valid0), 128'(0));

      // Reset around round 5 with in_valid high; block must be abandoned.
      w0 = kx_c1[1919 -: 1408];
      drive(0, 1'b1, CT_C1);
      tick();
      drive(0, 1'b0, 128'h0);
      repeat (4) tick();
      drive(0, 1'b1, CT_B);
      rst = 1'b1;
      tick();
      check("rmid_out_valid", 128'(out_valid0), 128'(0));
      check("rmid_pt",        pt0,              128'h0);
      check("rmid_in_ready",  128'(in_ready0),  128'(1));
      rst = 1'b0;
      drive(0, 1'b0, 128'h0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid0) seen = 1;
         tick();
      end
      check("rmid_no_output", 128'(seen), 128'(0));
      run_block(0, CT_C1, PT_C, "post_rst");
      tick();

      // Back-to-back with in_valid held high.
      w0 = kx_b[1919 -: 1408];
      p  = rand128();
      p2 = rand128();
      c  = encrypt(p, kx_b, 10);
      c2 = encrypt(p2, kx_b, 10);
      push(0, p);
      push(0, p2);
      drive(0, 1'b1, c);
      tick();
      drive(0, 1'b1, c2);
      n = 0;
      while (!out_valid0 && n < 40) begin tick(); n++; end
      check("b2b_first_valid", 128'(out_valid0), 128'(1));
      tick();
      hs = cyc;
      check("b2b_idle_after_hs", 128'(in_ready0), 128'(1));
      tick();
      check("b2b_second_accept", 128'(in_ready0), 128'(0));
      drive(0, 1'b0, 128'h0);
      n = 0;
      while (!out_valid0 && n < 40) begin tick(); n++; end
      check("b2b_second_latency", 128'(cyc - (hs + 1)), 128'(10));
      tick();

      // AES-256 instance.
      out_ready1 = 1'b1;
      w1 = kx_c3;
      run_block(1, CT_C3, PT_C, "kat_c3");
      tick();
      p = rand128();
      run_block(1, encrypt(p, kx_c3, 14), p, "rnd14");
      tick();

      repeat (3) tick();
      check("sb10_leftover", 128'(exp_q0.size()), 128'(0));
      check("sb14_leftover", 128'(exp_q1.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
